// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war playfield.
package tug_pkg;

    // Match phases: live play, dark pause between rounds, finished match.
    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Index of the middle LED of an odd-width row.
    function automatic int center_idx(input int num_lights);
        return (num_lights - 1) / 2;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX, with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 7
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count register: clear first, otherwise step up until MAX is reached.
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != WIDTH'(MAX))) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: moving light, edge scoring, serve pause and match end.
module tug_of_war_field
    import tug_pkg::*;
#(
    parameter int NUM_LIGHTS   = 9,
    parameter int WIN_ROUNDS   = 7,
    parameter int SERVE_CYCLES = 4,
    localparam int SW          = $clog2(WIN_ROUNDS + 1)
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  leftButton,
    input  logic                  rightButton,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [SW-1:0]         leftScore,
    output logic [SW-1:0]         rightScore,
    output logic                  pointLeft,
    output logic                  pointRight,
    output logic                  gameOver,
    output logic                  winnerRight
);

    localparam int                  CW         = $clog2(SERVE_CYCLES + 1);
    localparam int                  CENTER_IDX = center_idx(NUM_LIGHTS);
    localparam logic [NUM_LIGHTS-1:0] CENTER_LIT = NUM_LIGHTS'(1) << CENTER_IDX;

    state_e                  state_q, state_d;
    logic [NUM_LIGHTS-1:0]   lights_q, lights_d;
    logic [CW-1:0]           serve_q, serve_d;
    logic                    point_left_q, point_left_d;
    logic                    point_right_q, point_right_d;
    logic                    game_over_q, game_over_d;
    logic                    winner_right_q, winner_right_d;
    logic                    inc_left, inc_right;
    logic [SW-1:0]           left_score, right_score;
    logic                    left_final, right_final;

    // A point that brings a score to WIN_ROUNDS ends the match.
    assign left_final  = (left_score  == SW'(WIN_ROUNDS - 1));
    assign right_final = (right_score == SW'(WIN_ROUNDS - 1));

    sat_counter #(.WIDTH(SW), .MAX(WIN_ROUNDS)) u_left_score (
        .clk     (clk),
        .clr_i   (Reset),
        .inc_i   (inc_left),
        .count_o (left_score)
    );

    sat_counter #(.WIDTH(SW), .MAX(WIN_ROUNDS)) u_right_score (
        .clk     (clk),
        .clr_i   (Reset),
        .inc_i   (inc_right),
        .count_o (right_score)
    );

    // Next-state logic: light movement, scoring, serve countdown.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        lights_d       = lights_q;
        serve_d        = serve_q;
        point_left_d   = 1'b0;
        point_right_d  = 1'b0;
        game_over_d    = game_over_q;
        winner_right_d = winner_right_q;
        inc_left       = 1'b0;
        inc_right      = 1'b0;

        case (state_q)
            ST_PLAY: begin
                if (rightButton && !leftButton) begin
                    if (lights_q[0]) begin
                        inc_right     = 1'b1;
                        point_right_d = 1'b1;
                        lights_d      = '0;
                        if (right_final) begin
                            state_d        = ST_DONE;
                            game_over_d    = 1'b1;
                            winner_right_d = 1'b1;
                        end else begin
                            state_d = ST_SERVE;
                            serve_d = CW'(SERVE_CYCLES);
                        end
                    end else begin
                        lights_d = lights_q >> 1;
                    end
                end else if (leftButton && !rightButton) begin
                    if (lights_q[NUM_LIGHTS-1]) begin
                        inc_left     = 1'b1;
                        point_left_d = 1'b1;
                        lights_d     = '0;
                        if (left_final) begin
                            state_d        = ST_DONE;
                            game_over_d    = 1'b1;
                            winner_right_d = 1'b0;
                        end else begin
                            state_d = ST_SERVE;
                            serve_d = CW'(SERVE_CYCLES);
                        end
                    end else begin
                        lights_d = lights_q << 1;
                    end
                end
            end
            ST_SERVE: begin
                // The point cycle plus SERVE_CYCLES further cycles stay dark.
                if (serve_q == '0) begin
                    lights_d = CENTER_LIT;
                    state_d  = ST_PLAY;
                end else begin
                    serve_d = serve_q - CW'(1);
                end
            end
            ST_DONE: begin
                lights_d = '0;
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q        <= ST_PLAY;
            lights_q       <= CENTER_LIT;
            serve_q        <= '0;
            point_left_q   <= 1'b0;
            point_right_q  <= 1'b0;
            game_over_q    <= 1'b0;
            winner_right_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lights_q       <= lights_d;
            serve_q        <= serve_d;
            point_left_q   <= point_left_d;
            point_right_q  <= point_right_d;
            game_over_q    <= game_over_d;
            winner_right_q <= winner_right_d;
        end
    end

    assign lights      = lights_q;
    assign leftScore   = left_score;
    assign rightScore  = right_score;
    assign pointLeft   = point_left_q;
    assign pointRight  = point_right_q;
    assign gameOver    = game_over_q;
    assign winnerRight = winner_right_q;

endmodule

// File: tb/tb_tug_of_war_field.sv
// Scoreboard bench: instance A (9 lights, 2 rounds, 4 serve cycles),
// instance B (3 lights, 7 rounds, 1 serve cycle).
module tb_tug_of_war_field;

    typedef struct {
        bit          sel;      // 0 = instance A, 1 = instance B
        logic [18:0] vec;      // {lights[8:0], ls[2:0], rs[2:0], pl, pr, go, wr}
        string       name;
    } exp_t;

    logic clk;
    logic a_rst, a_l, a_r;
    logic b_rst, b_l, b_r;

    logic [8:0] a_lights;
    logic [1:0] a_ls, a_rs;
    logic       a_pl, a_pr, a_go, a_wr;
    logic [2:0] b_lights;
    logic [2:0] b_ls, b_rs;
    logic       b_pl, b_pr, b_go, b_wr;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    tug_of_war_field #(.NUM_LIGHTS(9), .WIN_ROUNDS(2), .SERVE_CYCLES(4)) dut_a (
        .clk         (clk),
        .Reset       (a_rst),
        .leftButton  (a_l),
        .rightButton (a_r),
        .lights      (a_lights),
        .leftScore   (a_ls),
        .rightScore  (a_rs),
        .pointLeft   (a_pl),
        .pointRight  (a_pr),
        .gameOver    (a_go),
        .winnerRight (a_wr)
    );

    tug_of_war_field #(.NUM_LIGHTS(3), .WIN_ROUNDS(7), .SERVE_CYCLES(1)) dut_b (
        .clk         (clk),
        .Reset       (b_rst),
        .leftButton  (b_l),
        .rightButton (b_r),
        .lights      (b_lights),
        .leftScore   (b_ls),
        .rightScore  (b_rs),
        .pointLeft   (b_pl),
        .pointRight  (b_pr),
        .gameOver    (b_go),
        .winnerRight (b_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    // Drive one cycle on the selected instance and queue the state expected after the edge.
    task automatic step(input bit sel, input bit rst, input bit l, input bit r,
                        input logic [8:0] el, input logic [2:0] ls, input logic [2:0] rs,
                        input bit pl, input bit pr, input bit go, input bit wr,
                        input string nm);
        exp_t e;
        a_rst = sel ? 1'b1 : rst;
        a_l   = sel ? 1'b0 : l;
        a_r   = sel ? 1'b0 : r;
        b_rst = sel ? rst : 1'b1;
        b_l   = sel ? l : 1'b0;
        b_r   = sel ? r : 1'b0;
        e.sel  = sel;
        e.vec  = {el, ls, rs, pl, pr, go, wr};
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: the DUT presents a new registered state every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [18:0] act;
            e = sb.pop_front();
            if (e.sel)
                act = {6'b0, b_lights, b_ls, b_rs, b_pl, b_pr, b_go, b_wr};
            else
                act = {a_lights, 1'b0, a_ls, 1'b0, a_rs, a_pl, a_pr, a_go, a_wr};
            check(e.name, act, e.vec);
        end
    end

    initial begin
        logic [8:0] c9;
        c9 = 9'h010;

        // ---- Instance A: reset, idle, both buttons ----
        step(0, 1, 0, 0, 9'h010, 0, 0, 0, 0, 0, 0, "a_reset");
        step(0, 0, 0, 0, 9'h010, 0, 0, 0, 0, 0, 0, "a_idle");
        step(0, 0, 1, 1, 9'h010, 0, 0, 0, 0, 0, 0, "a_both");
        // four right moves to the right edge, fifth scores
        for (int i = 1; i <= 4; i++)
            step(0, 0, 0, 1, c9 >> i, 0, 0, 0, 0, 0, 0, "a_move_r");
        step(0, 0, 0, 1, 9'h000, 0, 1, 0, 1, 0, 0, "a_point_r");
        // serve pause ignores presses
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 0, 9'h000, 0, 1, 0, 0, 0, 0, "a_serve_ignore");
        step(0, 0, 0, 0, 9'h010, 0, 1, 0, 0, 0, 0, "a_serve_end");
        // to the left edge, move away from it, back, then score left
        for (int i = 1; i <= 4; i++)
            step(0, 0, 1, 0, c9 << i, 0, 1, 0, 0, 0, 0, "a_move_l");
        step(0, 0, 0, 1, 9'h080, 0, 1, 0, 0, 0, 0, "a_away_edge");
        step(0, 0, 1, 0, 9'h100, 0, 1, 0, 0, 0, 0, "a_back_edge");
        step(0, 0, 1, 0, 9'h000, 1, 1, 1, 0, 0, 0, "a_point_l");
        // reset mid-serve with a press pending
        step(0, 1, 1, 0, 9'h010, 0, 0, 0, 0, 0, 0, "a_rst_serve");
        step(0, 0, 0, 0, 9'h010, 0, 0, 0, 0, 0, 0, "a_post_rst");

        // ---- Left wins the match ----
        for (int i = 1; i <= 4; i++)
            step(0, 0, 1, 0, c9 << i, 0, 0, 0, 0, 0, 0, "a_lw_move");
        step(0, 0, 1, 0, 9'h000, 1, 0, 1, 0, 0, 0, "a_lw_point1");
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 9'h000, 1, 0, 0, 0, 0, 0, "a_lw_serve");
        step(0, 0, 0, 0, 9'h010, 1, 0, 0, 0, 0, 0, "a_lw_center");
        for (int i = 1; i <= 4; i++)
            step(0, 0, 1, 0, c9 << i, 1, 0, 0, 0, 0, 0, "a_lw_move2");
        step(0, 0, 1, 0, 9'h000, 2, 0, 1, 0, 1, 0, "a_lw_win");
        step(0, 0, 1, 0, 9'h000, 2, 0, 0, 0, 1, 0, "a_done_l");
        step(0, 0, 0, 1, 9'h000, 2, 0, 0, 0, 1, 0, "a_done_r");
        step(0, 0, 1, 1, 9'h000, 2, 0, 0, 0, 1, 0, "a_done_both");
        step(0, 1, 0, 1, 9'h010, 0, 0, 0, 0, 0, 0, "a_rst_done");

        // ---- Right wins the match ----
        for (int i = 1; i <= 4; i++)
            step(0, 0, 0, 1, c9 >> i, 0, 0, 0, 0, 0, 0, "a_rw_move");
        step(0, 0, 0, 1, 9'h000, 0, 1, 0, 1, 0, 0, "a_rw_point1");
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 1, 9'h000, 0, 1, 0, 0, 0, 0, "a_rw_serve");
        step(0, 0, 0, 0, 9'h010, 0, 1, 0, 0, 0, 0, "a_rw_center");
        for (int i = 1; i <= 4; i++)
            step(0, 0, 0, 1, c9 >> i, 0, 1, 0, 0, 0, 0, "a_rw_move2");
        step(0, 0, 0, 1, 9'h000, 0, 2, 0, 1, 1, 1, "a_rw_win");
        step(0, 0, 1, 0, 9'h000, 0, 2, 0, 0, 1, 1, "a_rw_hold");
        step(0, 1, 0, 0, 9'h010, 0, 0, 0, 0, 0, 0, "a_rst_done2");

        // ---- Instance B: three lights, one serve cycle ----
        step(1, 1, 0, 0, 9'h002, 0, 0, 0, 0, 0, 0, "b_reset");
        step(1, 0, 0, 1, 9'h001, 0, 0, 0, 0, 0, 0, "b_move_r");
        step(1, 0, 0, 1, 9'h000, 0, 1, 0, 1, 0, 0, "b_point_r");
        step(1, 0, 1, 0, 9'h000, 0, 1, 0, 0, 0, 0, "b_serve");
        step(1, 0, 0, 0, 9'h002, 0, 1, 0, 0, 0, 0, "b_center");
        step(1, 0, 1, 0, 9'h004, 0, 1, 0, 0, 0, 0, "b_move_l");
        step(1, 0, 1, 0, 9'h000, 1, 1, 1, 0, 0, 0, "b_point_l");
        step(1, 0, 0, 0, 9'h000, 1, 1, 0, 0, 0, 0, "b_serve2");
        step(1, 0, 0, 0, 9'h002, 1, 1, 0, 0, 0, 0, "b_center2");

        // let the monitor consume the last entries
        @(posedge clk);
        @(posedge clk);
        check("drain", 19'(sb.size()), 19'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
